instr_encoder_loader: RTL and testbench

- Inverse of the immediate decoder: takes instruction fields plus a sign-extended immediate, in the same units the decoder produces, and packs them into a 32-bit RV32 instruction word.
- Streams the encoded words into instruction memory at consecutive addresses.
- Used by the rhythm-game program/chart loader to build programs in hardware.
- Two-stage pipeline with a valid/ready input handshake and a load state machine.

---
 rtl/isa_pkg.sv | 53 +++++
 rtl/instr_encoder_loader_if.sv | 28 ++
 rtl/instr_pack.sv | 48 ++++
 rtl/instr_encoder_loader.sv | 149 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// RV32 encoding constants, format classification and FSM state type shared by
// the instruction encoder/loader.
package isa_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Immediate limits in decoder units (B and J are halfword offsets).
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM20_MIN = -524288;
  localparam int IMM20_MAX = 524287;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_R,
    FMT_ILLEGAL
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: f = FMT_I;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_B;
      OP_JAL:                   f = FMT_J;
      OP_R:                     f = FMT_R;
      default:                  f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input channel of the instruction encoder/loader.
// A bundle transfers on a clock edge where in_valid && in_ready; the master holds
// every field stable while in_valid is high and in_ready is low, and in_ready never
// depends on in_valid.
interface instr_encoder_loader_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [WIDTH-1:0] in_imm;

  modport master (
    output in_valid, in_last, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output in_ready
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32 packer: instruction fields plus decoder-unit immediate
// to a 32-bit word and a legality flag.
module instr_pack
  import isa_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);
  fmt_e fmt;

  always_comb begin
    fmt     = fmt_of(opcode_i);
    word_o  = NOP;
    legal_o = 1'b0;
    case (fmt)
      FMT_I: begin
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal_o = imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      // B and J immediates arrive already divided by two, so bit k here is
      // bit k+1 of the byte offset in the ISA manual's layout.
      FMT_B: begin
        word_o  = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i, imm_i[3:0], imm_i[10], opcode_i};
        legal_o = imm_in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      FMT_J: begin
        word_o  = {imm_i[19], imm_i[9:0], imm_i[10], imm_i[18:11], rd_i, opcode_i};
        legal_o = imm_in_range(imm_i, IMM20_MIN, IMM20_MAX);
      end
      FMT_R: begin
        word_o  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field bundles and streams them to instruction memory at consecutive addresses.
// Build option NOP_PAD_EN: rejected bundles write a NOP instead of being dropped.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instr_encoder_loader_if.slave in_if,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            err_cnt,
  output logic [ADDR_W:0]       word_cnt,
  output state_e                dbg_state_o
);
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              stg_valid_q, stg_valid_d;
  logic              stg_last_q, stg_last_d;
  logic [WIDTH-1:0]  stg_word_q, stg_word_d;
  logic [31:0]       pack_word;
  logic              pack_legal;
  logic              accept;
  logic              full_resv;

  instr_pack u_pack (
    .opcode_i (in_if.in_opcode),
    .rd_i     (in_if.in_rd),
    .rs1_i    (in_if.in_rs1),
    .rs2_i    (in_if.in_rs2),
    .funct3_i (in_if.in_funct3),
    .funct7_i (in_if.in_funct7),
    .imm_i    (in_if.in_imm),
    .word_o   (pack_word),
    .legal_o  (pack_legal)
  );

  // The staged word is counted as already written so a full memory never
  // accepts one bundle too many.
  assign full_resv      = (cnt_q + (ADDR_W+1)'(stg_valid_q)) >= DEPTH_W;
  assign in_if.in_ready = (state_q == ST_LOAD) && !(stg_valid_q && stg_last_q) && !full_resv;
  assign accept         = in_if.in_valid && in_if.in_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    stg_valid_d = 1'b0;
    stg_last_d  = 1'b0;
    stg_word_d  = stg_word_q;

    if (stg_valid_q) begin
      ptr_d = ptr_q + ADDR_W'(1);
      cnt_d = cnt_q + (ADDR_W+1)'(1);
    end

    if (accept) begin
`ifdef NOP_PAD_EN
      stg_valid_d = 1'b1;
      stg_last_d  = in_if.in_last;
      stg_word_d  = pack_legal ? pack_word : NOP;
`else
      if (pack_legal) begin
        stg_valid_d = 1'b1;
        stg_last_d  = in_if.in_last;
        stg_word_d  = pack_word;
      end
`endif
      if (!pack_legal) begin
        err_d     = 1'b1;
        err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD;
          ptr_d     = BASE_W;
          cnt_d     = '0;
          err_d     = 1'b0;
          err_cnt_d = 8'd0;
        end
      end
      ST_LOAD: begin
        // A dropped last bundle ends the session at once; a written one ends
        // it on its write edge.
        if (accept && in_if.in_last && !stg_valid_d) begin
          state_d = ST_DONE;
        end else if (stg_valid_q && stg_last_q) begin
          state_d = ST_DONE;
        end else if ((cnt_q == DEPTH_W) && !stg_valid_q && in_if.in_valid) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= BASE_W;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      stg_valid_q <= 1'b0;
      stg_last_q  <= 1'b0;
      stg_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      stg_valid_q <= stg_valid_d;
      stg_last_q  <= stg_last_d;
      stg_word_q  <= stg_word_d;
    end
  end

  assign mem_we      = stg_valid_q;
  assign mem_addr    = stg_valid_q ? ptr_q : '0;
  assign mem_wdata   = stg_valid_q ? stg_word_q : '0;
  assign busy        = (state_q == ST_LOAD);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign word_cnt    = cnt_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed vectors, depth/reset boundaries and
// randomized sessions against a field-level encoding model with decode round-trip.
module tb_instr_encoder_loader;
  import isa_pkg::*;

  localparam int ADDR_W = 10;
  localparam int BASE   = 0;
  localparam int DEPTH  = 4;
  localparam int SBW    = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done, err;
  logic [7:0]        err_cnt;
  logic [ADDR_W:0]   word_cnt;
  state_e            dbg_state;

  instr_encoder_loader_if #(.WIDTH(32)) bus ();

  instr_encoder_loader #(.WIDTH(32), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_if       (bus),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_cnt     (err_cnt),
    .word_cnt    (word_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int passed = 0;

  logic [SBW-1:0]    exp_q[$];
  int                rt_imm_q[$];
  bit                rt_on_q[$];
  logic [ADDR_W-1:0] mptr;
  int                mcnt, merr, mecnt;

  logic [6:0] b_op, b_f7;
  logic [4:0] b_rd, b_rs1, b_rs2;
  logic [2:0] b_f3;
  int         b_imm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input int imm);
    logic [31:0] u, w, regs;
    bit ok;
    u = imm;
    w = 32'h0000_0013;
    ok = 1'b0;
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = ((u & 32'hFFF) << 20) | regs | (32'(rd) << 7) | 32'(op);
      end
      7'b0100011: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((u & 32'h1F) << 7) | 32'(op);
      end
      7'b1100011: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = (((u >> 11) & 32'h1) << 31) | (((u >> 4) & 32'h3F) << 25) | (32'(rs2) << 20) | regs
           | ((u & 32'hF) << 8) | (((u >> 10) & 32'h1) << 7) | 32'(op);
      end
      7'b1101111: begin
        ok = (imm >= -524288) && (imm <= 524287);
        w  = (((u >> 19) & 32'h1) << 31) | ((u & 32'h3FF) << 21) | (((u >> 10) & 32'h1) << 20)
           | (((u >> 11) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
      end
      7'b0110011: begin
        ok = 1'b1;
        w  = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'(op);
      end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  // Decoder view of a word: recovers the immediate in decoder units.
  function automatic int ref_decode(input logic [31:0] w);
    logic [11:0] i12;
    logic [19:0] i20;
    case (w[6:0])
      7'b1100011: begin i12 = {w[31], w[7], w[30:25], w[11:8]}; return int'($signed(i12)); end
      7'b1101111: begin i20 = {w[31], w[19:12], w[20], w[30:21]}; return int'($signed(i20)); end
      7'b0100011: begin i12 = {w[31:25], w[11:7]}; return int'($signed(i12)); end
      default:    begin i12 = w[31:20]; return int'($signed(i12)); end
    endcase
  endfunction

  task automatic model_push(input logic [31:0] w, input bit rt);
    exp_q.push_back({mptr, w});
    rt_on_q.push_back(rt);
    rt_imm_q.push_back(b_imm);
    mptr = mptr + ADDR_W'(1);
    mcnt++;
  endtask

  task automatic model_accept();
    logic [32:0] r;
    r = ref_encode(b_op, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_imm);
    if (r[32]) begin
      model_push(r[31:0], b_op != 7'b0110011);
    end else begin
      merr = 1;
      if (mecnt < 255) mecnt++;
`ifdef NOP_PAD_EN
      model_push(32'h0000_0013, 1'b0);
`endif
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    rt_on_q.delete();
    rt_imm_q.delete();
    mptr = ADDR_W'(BASE);
    mcnt = 0;
    merr = 0;
    mecnt = 0;
  endtask

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {22'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [SBW-1:0] e;
        bit rt;
        int im;
        e  = exp_q.pop_front();
        rt = rt_on_q.pop_front();
        im = rt_imm_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[SBW-1:32]));
        chk("wr_data", mem_wdata, e[31:0]);
        if (rt) chk("round_trip_imm", ref_decode(mem_wdata), im);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_bundle(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input int imm);
    b_op = op; b_rd = rd; b_rs1 = rs1; b_rs2 = rs2; b_f3 = f3; b_f7 = 7'd0; b_imm = imm;
  endtask

  task automatic send(input bit last, input int limit, output bit acc, output int cyc);
    bus.in_opcode = b_op;  bus.in_rd = b_rd;   bus.in_rs1 = b_rs1; bus.in_rs2 = b_rs2;
    bus.in_funct3 = b_f3;  bus.in_funct7 = b_f7; bus.in_imm = b_imm;
    bus.in_last = last;    bus.in_valid = 1'b1;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < limit) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    if (acc) model_accept();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_clear();
  endtask

  task automatic end_session(input string tag);
    int k;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(merr));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(mecnt));
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'(mcnt));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_bundle();
    int pick;
    bit bad, neg;
    pick  = $urandom_range(0, 7);
    bad   = ($urandom_range(0, 7) == 0);
    neg   = $urandom_range(0, 1) == 1;
    b_rd  = 5'($urandom);
    b_rs1 = 5'($urandom);
    b_rs2 = 5'($urandom);
    b_f3  = 3'($urandom);
    b_f7  = 7'($urandom);
    case (pick)
      0: b_op = 7'b0000011;
      1: b_op = 7'b0010011;
      2: b_op = 7'b1100111;
      3: b_op = 7'b0100011;
      4: b_op = 7'b1100011;
      5: b_op = 7'b1101111;
      6: b_op = 7'b0110011;
      default: b_op = 7'b0110111;
    endcase
    if (pick == 5) begin
      if (bad) b_imm = neg ? -524289 - int'($urandom_range(0, 1000)) : 524288 + int'($urandom_range(0, 1000));
      else     b_imm = int'($urandom_range(0, 1048575)) - 524288;
    end else if (pick == 6) begin
      b_imm = int'($urandom);
    end else begin
      if (bad) b_imm = neg ? -2049 - int'($urandom_range(0, 100)) : 2048 + int'($urandom_range(0, 100));
      else     b_imm = int'($urandom_range(0, 4095)) - 2048;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit acc;
    int cyc, n;

    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_opcode = '0; bus.in_rd = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Directed program filling all DEPTH words, last on the DEPTH-th
    do_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    set_bundle(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 5);
    send(1'b0, 4, acc, cyc);
    chk("addi_we", 32'(mem_we), 32'd1);
    chk("addi_addr", 32'(mem_addr), 32'(BASE));
    chk("addi_wdata", mem_wdata, 32'h0050_0093);
    set_bundle(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 8);
    send(1'b0, 4, acc, cyc);
    chk("sw_addr", 32'(mem_addr), 32'(BASE + 1));
    chk("sw_wdata", mem_wdata, 32'h0020_A423);
    set_bundle(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 4);
    send(1'b0, 4, acc, cyc);
    chk("beq_wdata", mem_wdata, 32'h0020_8463);
    set_bundle(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, -1);
    send(1'b1, 4, acc, cyc);
    chk("jal_wdata", mem_wdata, 32'hFFFF_F0EF);
    end_session("dir");

    // Out-of-range immediate
    do_start();
    set_bundle(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 2048);
    send(1'b1, 4, acc, cyc);
    chk("ill_acc", 32'(acc), 32'd1);
    end_session("ill");
    chk("ill_err_const", 32'(err), 32'd1);
    chk("ill_err_cnt_const", 32'(err_cnt), 32'd1);
`ifdef NOP_PAD_EN
    chk("ill_pad_word_cnt", 32'(word_cnt), 32'd1);
`else
    chk("ill_drop_word_cnt", 32'(word_cnt), 32'd0);
`endif

    // Five back-to-back bundles into a DEPTH=4 memory
    do_start();
    for (int j = 0; j < 5; j++) begin
      set_bundle(7'b0010011, 5'(j + 1), 5'd3, 5'd0, 3'd0, j * 3 - 5);
      if (j < 4) begin
        send(1'b0, 4, acc, cyc);
        chk("depth_acc", 32'(acc), 32'd1);
        chk("depth_no_stall", 32'(cyc), 32'd1);
      end else begin
        send(1'b0, 6, acc, cyc);
        chk("depth_fifth_rejected", 32'(acc), 32'd0);
      end
    end
    merr = 1;
    end_session("depth");
    chk("depth_in_ready", 32'(bus.in_ready), 32'd0);

    // Reset with a bundle sitting in the stage register
    do_start();
    set_bundle(7'b0010011, 5'd7, 5'd2, 5'd0, 3'd0, 100);
    send(1'b0, 4, acc, cyc);
    chk("mid_we_before_rst", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_no_write", 32'(mem_we), 32'd0);
    do_start();
    set_bundle(7'b0110011, 5'd5, 5'd6, 5'd7, 3'd0, 0);
    b_f7 = 7'b0100000;
    send(1'b1, 4, acc, cyc);
    chk("restart_addr", 32'(mem_addr), 32'(BASE));
    end_session("restart");

`ifndef NOP_PAD_EN
    // Error counter saturation: 256 rejected bundles in one session
    do_start();
    set_bundle(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 0);
    for (int j = 0; j < 256; j++) send(j == 255, 4, acc, cyc);
    end_session("sat");
    chk("sat_err_cnt_const", 32'(err_cnt), 32'd255);
`endif

    // Randomized sessions
    for (int s = 0; s < 12; s++) begin
      do_start();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        rand_bundle();
        send(i == n - 1, 4, acc, cyc);
        chk("rnd_acc", 32'(acc), 32'd1);
        chk("rnd_no_stall", 32'(cyc), 32'd1);
      end
      end_session("rnd");
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
